fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Sequences the instruction-fetch program counter and the instruction-memory request/response handshake for the 32-bit core.
- Replaces the free-running PC+4 increment with controlled fetch: it stalls on memory and decode backpressure, accepts branch/jump redirects, and discards stale responses after a redirect.
- Sits between the PC register logic, the instruction memory port and the decode stage.

Parameters:
- RESET_PC, 32'h00000000, first fetch address loaded on reset.
- PC_STEP, 32'd4, byte increment between sequential fetches.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req_valid_o  output  1  fetch request valid.
- imem_req_ready_i  input  1  memory accepts request.
- imem_req_addr_o  output  32  fetch address; always equals pc_o.
- imem_rsp_valid_i  input  1  response data valid; one response per accepted request, arriving at least 1 cycle after acceptance.
- imem_rsp_data_i  input  32  fetched instruction word.
- redirect_i  input  1  branch/jump taken; overrides sequential flow.
- redirect_pc_i  input  32  redirect target.
- inst_valid_o  output  1  instruction available to decode.
- inst_ready_i  input  1  decode accepts instruction.
- inst_o  output  32  held instruction word.
- inst_pc_o  output  32  address the held instruction was fetched from.
- pc_o  output  32  current fetch PC register.
- fetch_count_o  output  32  count of instructions delivered to decode (inst_valid_o && inst_ready_i); wraps 32'hFFFFFFFF -> 0.

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - state=REQ, pc_o=RESET_PC
  - inst_o=0, inst_pc_o=0, fetch_count_o=0
  - imem_req_valid_o=0 and inst_valid_o=0 while rst is high.
- Reset asserted in any state aborts the operation in progress. Any response for a pre-reset request is the memory's responsibility to squash.
- States:
  - REQ: imem_req_valid_o=1.
  - WAIT: request outstanding.
  - DROP: outstanding response is stale and must be discarded.
  - HOLD: instruction held for decode.
- Every state: redirect_i=1 loads pc_o<=redirect_pc_i. Redirect has priority over sequential update.
- REQ transitions:
  - handshake, no redirect -> WAIT.
  - handshake with redirect -> DROP.
  - no handshake, redirect -> stay REQ. The new address is presented next cycle.
- WAIT transitions:
  - rsp, no redirect: inst_o<=imem_rsp_data_i, inst_pc_o<=pc_o, pc_o<=pc_o+PC_STEP (mod 2^32) -> HOLD.
  - redirect, no rsp -> DROP.
  - redirect and rsp in the same cycle: discard rsp -> REQ.
- DROP transitions:
  - rsp -> REQ, data discarded, pc_o unchanged unless redirect that cycle.
  - no rsp -> stay DROP.
- HOLD: inst_valid_o = (state==HOLD) && !redirect_i, which is combinational so a redirected instruction is never handed over.
  - inst_ready_i with inst_valid_o -> fetch_count_o+1, -> REQ.
  - redirect -> held instruction dropped, -> REQ.
  - otherwise hold inst_o/inst_pc_o stable.
- Response arriving in REQ or HOLD is a protocol error. It is ignored; there is no state change.
- Best-case throughput: 1 instruction per 3 cycles (REQ, WAIT with 1-cycle memory, HOLD with ready=1).
- pc_o wraps 32'hFFFFFFFC + 4 -> 32'h00000000 without flagging.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output fetch_misalign_o (1 bit, reset 0).
  - A redirect with redirect_pc_i[1:0]!=0 loads pc_o, sets fetch_misalign_o=1 (sticky until rst), and enters a HALT state.
  - HALT issues no requests and keeps inst_valid_o=0, ignores further redirects, and discards any outstanding response.
- Not defined: redirect_pc_i[1:0] is forced to 2'b00 when loaded; there is no extra port or state.

Test Plan:
- Reset release, memory ready=1, 1-cycle response, inst_ready=1 -> requests at addr 0x0, 0x4, 0x8 on cycles 1, 4, 7; inst_pc_o 0x0/0x4/0x8; fetch_count_o=3.
- imem_req_ready_i=0 for 5 cycles in REQ -> imem_req_valid_o stays 1, addr 0x0 stable, pc_o unchanged.
- inst_ready_i=0 for 4 cycles in HOLD with inst 0x00500093 -> inst_valid_o=1, inst_o and inst_pc_o stable, no new request, fetch_count_o unchanged.
- Redirect to 0x100 while WAIT at pc 0x8 -> next response discarded in DROP, next request addr 0x100, inst_pc_o of next delivered instruction 0x100.
- Redirect to 0x200 and rsp in the same WAIT cycle -> response dropped, next cycle REQ with addr 0x200; redirect in HOLD -> inst_valid_o=0 that cycle, count unchanged.
- FETCH_MISALIGN_TRAP_EN defined: redirect to 0x102 -> fetch_misalign_o=1, no further imem_req_valid_o; undefined: next request addr 0x100.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequences the instruction-fetch PC and the instruction-memory
// request/response handshake. It stalls on memory and decode backpressure,
// takes branch/jump redirects and discards responses made stale by a redirect.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a misaligned redirect target raises the sticky fetch_misalign_o
//               and parks the fetcher in HALT until reset.
//   undefined : redirect targets are forced to word alignment.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   imem_req_*          fetch request (valid/ready/addr, addr == pc_o)
//   imem_rsp_*          fetch response (one per accepted request)
//   redirect_i/_pc_i    branch/jump redirect and target
//   inst_valid_o/ready  handshake to decode, inst_o/inst_pc_o held payload
//   pc_o                current fetch PC
//   fetch_count_o       instructions handed to decode (wrapping)
//   fetch_misalign_o    sticky misaligned-redirect flag (feature build only)

module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid_o,
   input  logic        imem_req_ready_i,
   output logic [31:0] imem_req_addr_o,
   input  logic        imem_rsp_valid_i,
   input  logic [31:0] imem_rsp_data_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   output logic [31:0] pc_o,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic        fetch_misalign_o,
`endif
   output logic [31:0] fetch_count_o
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [2:0] {
      S_REQ  = 3'd0,
      S_WAIT = 3'd1,
      S_DROP = 3'd2,
      S_HOLD = 3'd3
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      S_HALT = 3'd4
`endif
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   inst_q, inst_d;
   logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
   logic [XLEN-1:0]   count_q, count_d;

   logic              redirect_c;    // redirect that is actually honoured
   logic              trap_c;        // redirect to a misaligned target
   logic [XLEN-1:0]   redir_pc_c;    // target as loaded into the PC
   logic              req_hs_c;
   logic              inst_valid_c;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic              misalign_q, misalign_d;

   // Once halted, redirects are ignored; misaligned targets load unmodified.
   always_comb begin
      redirect_c = redirect_i && (state_q != S_HALT);
      trap_c     = redirect_c && (redirect_pc_i[1:0] != 2'b00);
      redir_pc_c = redirect_pc_i;
   end
`else
   // Targets are forced to word alignment.
   always_comb begin
      redirect_c = redirect_i;
      trap_c     = 1'b0;
      redir_pc_c = redirect_pc_i & 32'hFFFF_FFFC;
   end
`endif

   assign req_hs_c = imem_req_valid_o && imem_req_ready_i;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_REQ;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_REQ:  if (req_hs_c) state_d = redirect_c ? S_DROP : S_WAIT;
         S_WAIT: begin
            if (redirect_c)            state_d = imem_rsp_valid_i ? S_REQ : S_DROP;
            else if (imem_rsp_valid_i) state_d = S_HOLD;
         end
         S_DROP: if (imem_rsp_valid_i) state_d = S_REQ;
         // Held instruction leaves on delivery or is dropped by a redirect.
         S_HOLD: if (redirect_c || inst_ready_i) state_d = S_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
         S_HALT: state_d = S_HALT;
`endif
         default: state_d = S_REQ;
      endcase
`ifdef FETCH_MISALIGN_TRAP_EN
      if (trap_c) state_d = S_HALT;
`endif
   end

   // Output logic; both valids are suppressed while reset is held.
   always_comb begin
      imem_req_valid_o = 1'b0;
      inst_valid_c     = 1'b0;
      if (!rst) begin
         imem_req_valid_o = (state_q == S_REQ);
         inst_valid_c     = (state_q == S_HOLD) && !redirect_i;
      end
   end

   // Datapath next values; redirect overrides the sequential PC update.
   always_comb begin
      pc_d      = pc_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      count_d   = count_q;
      if (state_q == S_WAIT && imem_rsp_valid_i && !redirect_c) begin
         inst_d    = imem_rsp_data_i;
         inst_pc_d = pc_q;
         pc_d      = pc_q + PC_STEP;
      end
      if (redirect_c) pc_d = redir_pc_c;
      if (inst_valid_c && inst_ready_i) count_d = count_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         inst_q    <= '0;
         inst_pc_q <= '0;
         count_q   <= '0;
      end else begin
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
         count_q   <= count_d;
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   assign misalign_d = misalign_q | trap_c;

   always_ff @(posedge clk) begin
      if (rst) misalign_q <= 1'b0;
      else     misalign_q <= misalign_d;
   end

   assign fetch_misalign_o = misalign_q;
`endif

   assign imem_req_addr_o = pc_q;
   assign pc_o            = pc_q;
   assign inst_valid_o    = inst_valid_c;
   assign inst_o          = inst_q;
   assign inst_pc_o       = inst_pc_q;
   assign fetch_count_o   = count_q;

endmodule
